jpeg_bitstream_packer: RTL and testbench



---
 rtl/jpeg_bitstream_packer.sv | 168 ++++++++++++++++
 tb/tb_jpeg_bitstream_packer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_bitstream_packer.sv
// Packs right-aligned variable-length Huffman codes MSB-first into a byte-stuffed JPEG stream.
// Define JPEG_BITPACK_EOI_EN to append the EOI marker (0xFF 0xD9) after every flush.
module jpeg_bitstream_packer #(
    parameter int CODE_W = 24,
    parameter int LEN_W  = 5,
    parameter int ACC_W  = 40
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] code_data,
    input  logic [LEN_W-1:0]  code_len,
    input  logic              flush,
    output logic              flush_done,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic [7:0]        byte_data,
    output logic [31:0]       byte_count
);
    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam logic [CNT_W-1:0] ROOM     = CNT_W'(ACC_W - CODE_W);
    localparam logic [CNT_W-1:0] ACC_BITS = CNT_W'(ACC_W);
    localparam logic [CNT_W-1:0] EIGHT    = CNT_W'(8);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
`ifdef JPEG_BITPACK_EOI_EN
        ST_EOI1,
        ST_EOI2,
`endif
        ST_DONE
    } state_t;

`ifdef JPEG_BITPACK_EOI_EN
    localparam state_t AFTER_DRAIN = ST_EOI1;
`else
    localparam state_t AFTER_DRAIN = ST_DONE;
`endif

    state_t            state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
    logic              stuff_pending_reg, stuff_pending_next;
    logic              code_ready_reg, code_ready_next;
    logic              flush_done_reg, flush_done_next;
    logic              byte_valid_reg, byte_valid_next;
    logic [7:0]        byte_data_reg, byte_data_next;
    logic [31:0]       byte_count_reg, byte_count_next;

    logic [LEN_W-1:0]  len_sat;
    logic [CODE_W-1:0] code_masked;
    logic [CNT_W-1:0]  len_ext, shift_amt, merged_cnt;
    logic [ACC_W-1:0]  merged_acc;
    logic [7:0]        top_byte, pad_byte;
    logic              accept, load_en;

    assign len_sat = (code_len > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : code_len;

    // Bits at or above the code length are don't-care on the input and must not leak into the stream.
    for (genvar gi = 0; gi < CODE_W; gi++) begin : g_mask
        localparam logic [LEN_W-1:0] IDX = LEN_W'(gi);
        assign code_masked[gi] = code_data[gi] & (len_sat > IDX);
    end

    assign accept     = code_valid & code_ready_reg;
    assign load_en    = ~byte_valid_reg | byte_ready;
    assign len_ext    = CNT_W'(len_sat);
    assign shift_amt  = ACC_BITS - bit_cnt_reg - len_ext;
    // The accepted code is merged before extraction so a completing code yields a byte next cycle.
    assign merged_acc = accept ? (acc_reg | (ACC_W'(code_masked) << shift_amt)) : acc_reg;
    assign merged_cnt = accept ? (bit_cnt_reg + len_ext) : bit_cnt_reg;
    assign top_byte   = merged_acc[ACC_W-1 -: 8];
    assign pad_byte   = top_byte | (8'hFF >> merged_cnt[2:0]);

    always_comb begin
        state_next         = state_reg;
        acc_next           = merged_acc;
        bit_cnt_next       = merged_cnt;
        stuff_pending_next = stuff_pending_reg;
        byte_valid_next    = byte_valid_reg & ~byte_ready;
        byte_data_next     = byte_data_reg;
        flush_done_next    = 1'b0;
        byte_count_next    = byte_count_reg + ((byte_valid_reg & byte_ready) ? 32'd1 : 32'd0);

        if (state_reg == ST_RUN && flush) begin
            state_next = ST_DRAIN;
        end

        if (load_en) begin
            if (stuff_pending_reg) begin
                byte_data_next     = 8'h00;
                byte_valid_next    = 1'b1;
                stuff_pending_next = 1'b0;
            end else if (merged_cnt >= EIGHT) begin
                byte_data_next     = top_byte;
                byte_valid_next    = 1'b1;
                stuff_pending_next = (top_byte == 8'hFF);
                acc_next           = merged_acc << 8;
                bit_cnt_next       = merged_cnt - EIGHT;
            end else begin
                case (state_reg)
                    ST_RUN: ;
                    ST_DRAIN: begin
                        if (merged_cnt != '0) begin
                            byte_data_next     = pad_byte;
                            byte_valid_next    = 1'b1;
                            stuff_pending_next = (pad_byte == 8'hFF);
                            acc_next           = '0;
                            bit_cnt_next       = '0;
                        end
                        state_next = AFTER_DRAIN;
                    end
`ifdef JPEG_BITPACK_EOI_EN
                    ST_EOI1: begin
                        byte_data_next  = 8'hFF;
                        byte_valid_next = 1'b1;
                        state_next      = ST_EOI2;
                    end
                    ST_EOI2: begin
                        byte_data_next  = 8'hD9;
                        byte_valid_next = 1'b1;
                        state_next      = ST_DONE;
                    end
`endif
                    ST_DONE: begin
                        flush_done_next = 1'b1;
                        state_next      = ST_RUN;
                    end
                    default: state_next = ST_RUN;
                endcase
            end
        end

        code_ready_next = (state_next == ST_RUN) && (bit_cnt_next <= ROOM);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_RUN;
            acc_reg           <= '0;
            bit_cnt_reg       <= '0;
            stuff_pending_reg <= 1'b0;
            code_ready_reg    <= 1'b0;
            flush_done_reg    <= 1'b0;
            byte_valid_reg    <= 1'b0;
            byte_data_reg     <= 8'h00;
            byte_count_reg    <= 32'd0;
        end else begin
            state_reg         <= state_next;
            acc_reg           <= acc_next;
            bit_cnt_reg       <= bit_cnt_next;
            stuff_pending_reg <= stuff_pending_next;
            code_ready_reg    <= code_ready_next;
            flush_done_reg    <= flush_done_next;
            byte_valid_reg    <= byte_valid_next;
            byte_data_reg     <= byte_data_next;
            byte_count_reg    <= byte_count_next;
        end
    end

    assign code_ready = code_ready_reg;
    assign flush_done = flush_done_reg;
    assign byte_valid = byte_valid_reg;
    assign byte_data  = byte_data_reg;
    assign byte_count = byte_count_reg;
endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Bench for jpeg_bitstream_packer: fixed vectors, multi-cycle corner sequences and randomized
// traffic checked against a bit-queue model; honours JPEG_BITPACK_EOI_EN when defined.
module tb_jpeg_bitstream_packer;
    localparam int CODE_W = 24;
    localparam int LEN_W  = 5;
    localparam int ACC_W  = 40;
`ifdef JPEG_BITPACK_EOI_EN
    localparam bit EOI_EN = 1'b1;
`else
    localparam bit EOI_EN = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              code_valid = 1'b0;
    logic              code_ready;
    logic [CODE_W-1:0] code_data = '0;
    logic [LEN_W-1:0]  code_len = '0;
    logic              flush = 1'b0;
    logic              flush_done;
    logic              byte_valid;
    logic              byte_ready = 1'b0;
    logic [7:0]        byte_data;
    logic [31:0]       byte_count;

    jpeg_bitstream_packer #(.CODE_W(CODE_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
        .clock(clock), .reset(reset),
        .code_valid(code_valid), .code_ready(code_ready),
        .code_data(code_data), .code_len(code_len),
        .flush(flush), .flush_done(flush_done),
        .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_data(byte_data), .byte_count(byte_count)
    );

    initial forever #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_take = -1;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    bit          model_bits[$];
    logic [31:0] exp_count = 32'd0;

    always @(posedge clock) begin
        cyc++;
        if (!reset && byte_valid && byte_ready) begin
            got_q.push_back(byte_data);
            last_take = cyc;
            $display("byte %02h taken at cycle %0d", byte_data, cyc);
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got %0d bytes required completion", got_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model: a plain queue of pending bits, bytes cut off the front.
    task automatic m_push_byte(logic [7:0] b, bit stuffable);
        exp_q.push_back(b);
        exp_count++;
        if (stuffable && b == 8'hFF) begin
            exp_q.push_back(8'h00);
            exp_count++;
        end
    endtask

    task automatic m_code(int len, logic [23:0] data);
        int l;
        logic [7:0] b;
        l = (len > CODE_W) ? CODE_W : len;
        for (int i = l - 1; i >= 0; i--) model_bits.push_back(data[i]);
        while (model_bits.size() >= 8) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) b = {b[6:0], model_bits.pop_front()};
            m_push_byte(b, 1'b1);
        end
    endtask

    task automatic m_flush();
        logic [7:0] b;
        if (model_bits.size() > 0) begin
            b = 8'h00;
            for (int k = 0; k < 8; k++) b = {b[6:0], (model_bits.size() > 0) ? model_bits.pop_front() : 1'b1};
            m_push_byte(b, 1'b1);
        end
        if (EOI_EN) begin
            m_push_byte(8'hFF, 1'b0);
            m_push_byte(8'hD9, 1'b0);
        end
    endtask

    task automatic cmp_stream(string name);
        int n;
        check({name, " byte total"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("%s byte%0d", name, i), got_q[i], exp_q[i]);
        check({name, " byte_count"}, byte_count, exp_count);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_code(int len, logic [23:0] data, bit use_model);
        bit ok;
        ok = 1'b0;
        code_valid = 1'b1;
        code_len   = LEN_W'(len);
        code_data  = data;
        for (int c = 0; c < 200; c++) begin
            ok = code_ready;
            tick();
            if (ok) break;
        end
        code_valid = 1'b0;
        check("code accepted", 32'(ok), 32'd1);
        if (ok && use_model) m_code(len, data);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_done(string name, bit rand_ready, bit chk_timing);
        bit found;
        found = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (rand_ready) byte_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (flush_done) begin
                found = 1'b1;
                break;
            end
        end
        byte_ready = 1'b1;
        check({name, " flush_done seen"}, 32'(found), 32'd1);
        if (found) begin
            if (chk_timing) check({name, " flush_done after last take"}, 32'(cyc), 32'(last_take));
            check({name, " output empty at done"}, 32'(byte_valid), 32'd0);
            tick();
            check({name, " flush_done width"}, 32'(flush_done), 32'd0);
        end
    endtask

    typedef struct packed {
        logic [1:0]  n_codes;
        logic [4:0]  len0;
        logic [23:0] data0;
        logic [4:0]  len1;
        logic [23:0] data1;
        logic        pads;
        logic [2:0]  n_exp;
        logic [39:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vec_t v;
        bit   acc;

        vecs[0] = '{2'd2, 5'd4,  24'h12345A, 5'd4, 24'h000005, 1'b0, 3'd1, 40'hA500000000};
        vecs[1] = '{2'd1, 5'd16, 24'h00FF12, 5'd0, 24'h000000, 1'b0, 3'd3, 40'hFF00120000};
        vecs[2] = '{2'd1, 5'd3,  24'h000005, 5'd0, 24'h000000, 1'b1, 3'd1, 40'hBF00000000};
        vecs[3] = '{2'd1, 5'd2,  24'h000003, 5'd0, 24'h000000, 1'b1, 3'd2, 40'hFF00000000};
        vecs[4] = '{2'd2, 5'd0,  24'hABCDEF, 5'd8, 24'h0001C3, 1'b0, 3'd1, 40'hC300000000};
        vecs[5] = '{2'd1, 5'd31, 24'h123456, 5'd0, 24'h000000, 1'b0, 3'd3, 40'h1234560000};
        vecs[6] = '{2'd2, 5'd12, 24'h000FFF, 5'd4, 24'h000000, 1'b0, 3'd3, 40'hFF00F00000};
        vecs[7] = '{2'd2, 5'd1,  24'h000001, 5'd7, 24'h00007F, 1'b0, 3'd2, 40'hFF00000000};
        vecs[8] = '{2'd0, 5'd0,  24'h000000, 5'd0, 24'h000000, 1'b0, 3'd0, 40'h0000000000};
        vecs[9] = '{2'd2, 5'd5,  24'h000016, 5'd6, 24'h00000D, 1'b1, 3'd2, 40'hB1BF000000};

        // Reset values
        tick();
        check("reset code_ready", 32'(code_ready), 32'd0);
        check("reset byte_valid", 32'(byte_valid), 32'd0);
        check("reset byte_data", 32'(byte_data), 32'd0);
        check("reset flush_done", 32'(flush_done), 32'd0);
        check("reset byte_count", byte_count, 32'd0);
        #17 reset = 1'b0;
        tick();
        check("code_ready after reset", 32'(code_ready), 32'd1);

        // Fixed vectors
        byte_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            if (v.n_codes >= 2'd1) send_code(int'(v.len0), v.data0, 1'b0);
            if (v.n_codes >= 2'd2) send_code(int'(v.len1), v.data1, 1'b0);
            for (int k = 0; k < int'(v.n_exp); k++) begin
                exp_q.push_back(v.exp[39 - 8*k -: 8]);
                exp_count++;
            end
            if (EOI_EN) begin
                exp_q.push_back(8'hFF);
                exp_q.push_back(8'hD9);
                exp_count += 32'd2;
            end
            do_flush();
            wait_done($sformatf("vec%0d", i), 1'b0, v.pads || EOI_EN);
            cmp_stream($sformatf("vec%0d", i));
        end

        // Backpressure with a stalled output register
        byte_ready = 1'b0;
        code_valid = 1'b1;
        code_len   = 5'd24;
        code_data  = 24'hABCDEF;
        for (int c = 0; c < 10; c++) begin
            acc = code_ready;
            tick();
            if (acc) m_code(24, 24'hABCDEF);
            check("bp byte_valid held", 32'(byte_valid), 32'd1);
            check("bp byte_data held", 32'(byte_data), 32'hAB);
        end
        check("bp code_ready low", 32'(code_ready), 32'd0);
        byte_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            acc = code_ready;
            tick();
            if (acc) m_code(24, 24'hABCDEF);
        end
        code_valid = 1'b0;
        do_flush();
        m_flush();
        wait_done("backpressure", 1'b0, 1'b0);
        cmp_stream("backpressure");

        // Randomized rounds; each ends with a flush offered together with one more code
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 60; c++) begin
                code_valid = ($urandom_range(0, 1) == 1);
                code_len   = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(25, 31))
                                                          : LEN_W'($urandom_range(0, 24));
                code_data  = CODE_W'($urandom);
                byte_ready = ($urandom_range(0, 3) != 0);
                acc = code_valid && code_ready;
                tick();
                if (acc) m_code(int'(code_len), code_data);
            end
            code_valid = 1'b1;
            code_len   = LEN_W'($urandom_range(1, 24));
            code_data  = CODE_W'($urandom);
            flush      = 1'b1;
            acc = code_ready;
            tick();
            if (acc) m_code(int'(code_len), code_data);
            m_flush();
            flush      = 1'b0;
            code_valid = 1'b0;
            wait_done($sformatf("rand%0d", r), 1'b1, 1'b0);
            cmp_stream($sformatf("rand%0d", r));
        end

        // Reset while draining with five bits buffered and the output stalled
        byte_ready = 1'b0;
        send_code(13, 24'h00ABCD, 1'b0);
        do_flush();
        tick();
        check("pre-reset stalled byte", 32'(byte_data), 32'h5E);
        #3 reset = 1'b1;
        #1;
        check("mid-flush reset byte_valid", 32'(byte_valid), 32'd0);
        check("mid-flush reset code_ready", 32'(code_ready), 32'd0);
        check("mid-flush reset byte_count", byte_count, 32'd0);
        got_q.delete();
        exp_q.delete();
        model_bits.delete();
        exp_count = 32'd0;
        #10 reset = 1'b0;
        tick();
        check("post-reset code_ready", 32'(code_ready), 32'd1);
        byte_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        check("post-reset residual bytes", got_q.size(), 32'd0);
        check("post-reset byte_count", byte_count, 32'd0);
        check("post-reset flush_done", 32'(flush_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
